// File: rtl/fabric_arbiter.sv
// Round-robin arbiter for the shared data fabric: one-hot grant held per transfer, one-cycle turnaround.
// Optional grant-length timeout with abort/mask is enabled by defining FABRIC_ARB_TIMEOUT_EN.
module fabric_arbiter #(
    parameter int unsigned NUM_UNITS = 4,
    parameter int unsigned TIMEOUT   = 64,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                 CLK_B,
    input  logic                 RESET,
    input  logic [NUM_UNITS-1:0] REQ,
    input  logic                 MEM_BUSY,
    output logic [NUM_UNITS-1:0] EN,
    output logic [3:0]           GRANT_ID,
    output logic                 BUS_BUSY,
    output logic                 TIMEOUT_ERR,
    output logic [3:0]           ERR_ID
);

    localparam int unsigned ID_W = 4;

    if (NUM_UNITS < 1 || NUM_UNITS > 16 || TIMEOUT < 2 || (64'(1) << CNT_W) < 64'(TIMEOUT)) begin : g_cfg_err
        $error("fabric_arbiter: illegal NUM_UNITS/TIMEOUT/CNT_W combination");
    end

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_GAP   = 2'd2
    } state_t;

    state_t               state, state_nxt;
    logic [ID_W-1:0]      ptr, ptr_nxt, ptr_adv;
    logic [NUM_UNITS-1:0] en_nxt, elig;
    logic [ID_W-1:0]      gid_nxt, win_id;
    logic                 busy_nxt, win_vld, req_held;
    int unsigned          cand;

`ifdef FABRIC_ARB_TIMEOUT_EN
    logic [CNT_W-1:0]     cnt, cnt_nxt;
    logic [NUM_UNITS-1:0] mask, mask_nxt;
    logic                 terr_nxt, tmo_hit;
    logic [ID_W-1:0]      eid_nxt;
`endif

    // Eligible set, rotating first-set search from ptr, and state of the granted unit's request
    always_comb begin
`ifdef FABRIC_ARB_TIMEOUT_EN
        elig = REQ & ~mask;
`else
        elig = REQ;
`endif
        win_vld  = 1'b0;
        win_id   = '0;
        cand     = 0;
        req_held = 1'b0;
        for (int unsigned i = 0; i < NUM_UNITS; i++) begin
            cand = (32'(ptr) + i) % NUM_UNITS;
            for (int unsigned j = 0; j < NUM_UNITS; j++) begin
                if (!win_vld && j == cand && elig[j]) begin
                    win_vld = 1'b1;
                    win_id  = ID_W'(j);
                end
            end
        end
        for (int unsigned j = 0; j < NUM_UNITS; j++) begin
            if (ID_W'(j) == GRANT_ID) req_held = REQ[j];
        end
        ptr_adv = ID_W'((32'(GRANT_ID) + 32'd1) % NUM_UNITS);
    end

`ifdef FABRIC_ARB_TIMEOUT_EN
    assign tmo_hit = (cnt == CNT_W'(TIMEOUT - 1));
`endif

    // Next-state and next-output logic; GAP arbitrates on its exit edge so the bus idles one cycle
    always_comb begin
        state_nxt = state;
        ptr_nxt   = ptr;
        en_nxt    = EN;
        gid_nxt   = GRANT_ID;
        busy_nxt  = BUS_BUSY;
`ifdef FABRIC_ARB_TIMEOUT_EN
        cnt_nxt   = cnt;
        mask_nxt  = mask & REQ;
        terr_nxt  = 1'b0;
        eid_nxt   = ERR_ID;
`endif
        case (state)
            S_IDLE, S_GAP: begin
                en_nxt    = '0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
                if (win_vld && !MEM_BUSY) begin
                    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
                        en_nxt[j] = (ID_W'(j) == win_id);
                    end
                    gid_nxt   = win_id;
                    busy_nxt  = 1'b1;
                    state_nxt = S_GRANT;
`ifdef FABRIC_ARB_TIMEOUT_EN
                    cnt_nxt   = '0;
`endif
                end
            end
            S_GRANT: begin
`ifdef FABRIC_ARB_TIMEOUT_EN
                cnt_nxt = cnt + 1'b1;
`endif
                if (!req_held) begin
                    en_nxt    = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = ptr_adv;
                    state_nxt = S_GAP;
                end
`ifdef FABRIC_ARB_TIMEOUT_EN
                else if (tmo_hit) begin
                    en_nxt    = '0;
                    busy_nxt  = 1'b0;
                    ptr_nxt   = ptr_adv;
                    terr_nxt  = 1'b1;
                    eid_nxt   = GRANT_ID;
                    state_nxt = S_GAP;
                    for (int unsigned j = 0; j < NUM_UNITS; j++) begin
                        if (ID_W'(j) == GRANT_ID) mask_nxt[j] = 1'b1;
                    end
                end
`endif
            end
            default: begin
                en_nxt    = '0;
                busy_nxt  = 1'b0;
                state_nxt = S_IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            state    <= S_IDLE;
            ptr      <= '0;
            EN       <= '0;
            GRANT_ID <= '0;
            BUS_BUSY <= 1'b0;
        end else begin
            state    <= state_nxt;
            ptr      <= ptr_nxt;
            EN       <= en_nxt;
            GRANT_ID <= gid_nxt;
            BUS_BUSY <= busy_nxt;
        end
    end

`ifdef FABRIC_ARB_TIMEOUT_EN
    always_ff @(posedge CLK_B or negedge RESET) begin
        if (!RESET) begin
            cnt         <= '0;
            mask        <= '0;
            TIMEOUT_ERR <= 1'b0;
            ERR_ID      <= '0;
        end else begin
            cnt         <= cnt_nxt;
            mask        <= mask_nxt;
            TIMEOUT_ERR <= terr_nxt;
            ERR_ID      <= eid_nxt;
        end
    end
`else
    assign TIMEOUT_ERR = 1'b0;
    assign ERR_ID      = '0;
`endif

endmodule

// File: doc/fabric_arbiter.md
Name: fabric_arbiter

Overview:
- Round-robin arbiter for the shared data fabric (SA_D3/SB_D2/SC_D1/IP_D0 bus, WRITEFD/READFD/ADDRFD strobes).
- Code loaders request the bus with REQUEST and NUMBER_UNIT. This block returns a one-hot EN to a single unit.
- It holds the grant for the whole transfer, inserts a one-cycle turnaround gap, and aborts a transfer that holds the bus too long.
- Sits in the fabric-control block, between all loader units and the fabric-data mux.

Parameters:
- NUM_UNITS, 4, number of requesters (1..16).
- TIMEOUT, 64, maximum grant length in CLK_B cycles (≥2).
- CNT_W, 8, width of the grant-length counter (2**CNT_W ≥ TIMEOUT).

Ports:
- CLK_B  input  1  fabric clock (200 MHz domain)
- RESET  input  1  asynchronous active-low reset
- REQ  input  NUM_UNITS  per-unit REQUEST lines, level-held for the whole transfer
- MEM_BUSY  input  1  fabric slave busy (BUSY_line_SLAVE); no new grant while high
- EN  output  NUM_UNITS  one-hot grant to the units
- GRANT_ID  output  4  index of the granted unit (NUMBER_UNIT encoding); valid while BUS_BUSY
- BUS_BUSY  output  1  high while any grant is active
- TIMEOUT_ERR  output  1  one-cycle pulse when a grant is aborted
- ERR_ID  output  4  unit index latched at the last abort

Behaviour:
- One clock, CLK_B; reset is asynchronous and active-low, port RESET.
- Reset values:
  - EN=0, GRANT_ID=0, BUS_BUSY=0, TIMEOUT_ERR=0, ERR_ID=0.
  - Round-robin pointer PTR=0, counter CNT=0, MASK=0, state IDLE.
- Reset mid-grant drops EN immediately (asynchronously).
- States: IDLE, GRANT, GAP.
- IDLE:
  - Eligible set E = REQ & ~MASK.
  - If E≠0 and MEM_BUSY=0, the winner is the first set bit of E searching from PTR upward, with wrap-around.
  - At that edge: EN[winner]=1, GRANT_ID=winner, BUS_BUSY=1, CNT=0, go to GRANT.
  - Latency: REQ high before edge k gives EN high after edge k (1 cycle).
  - If MEM_BUSY=1, stay in IDLE; requests wait, none are lost.
- GRANT:
  - CNT increments every cycle. EN is stable; changes on other REQ lines are ignored.
  - If REQ[GRANT_ID] falls: EN=0, BUS_BUSY=0, PTR=GRANT_ID+1 (mod NUM_UNITS), go to GAP.
  - Timeout: if CNT==TIMEOUT-1 with REQ[GRANT_ID] still high:
    - EN=0, BUS_BUSY=0, TIMEOUT_ERR=1 for one cycle, ERR_ID=GRANT_ID.
    - MASK[GRANT_ID]=1, PTR advances as above, go to GAP.
  - If release and timeout fall on the same edge, release wins and no error is raised.
- GAP:
  - Exactly one cycle with all EN low (bus turnaround), then IDLE.
  - Back-to-back grants are therefore separated by ≥1 idle cycle.
- MASK:
  - MASK[i] clears on any edge where REQ[i]=0.
  - A timed-out unit is therefore not regranted until it drops and re-raises REQ.
- Simultaneous requests: lowest index ≥PTR wins. After reset (PTR=0), unit 0 has priority.
- REQ bits at indices ≥NUM_UNITS do not exist. GRANT_ID upper bits are 0 when NUM_UNITS<16.
- Invariant: popcount(EN)≤1 at all times; EN≠0 iff BUS_BUSY.

Optional Feature:
- Macro: FABRIC_ARB_TIMEOUT_EN.
- Defined:
  - Timeout logic, MASK, TIMEOUT_ERR and ERR_ID operate as above.
- Undefined:
  - No counter and no MASK; a grant lasts until REQ falls, however long.
  - TIMEOUT_ERR and ERR_ID are tied to 0.
  - TIMEOUT and CNT_W are ignored.

Test Plan:
- Reset, then REQ=4'b0001 for 5 cycles then 0 → EN=0001 one cycle after REQ, held 5 cycles, then GAP with EN=0 for one cycle; GRANT_ID=0; PTR=1.
- REQ=4'b1111 held, each unit dropping REQ 3 cycles after its grant → grant order 0,1,2,3,0; one cycle of EN=0 between each; never two EN bits high.
- REQ=4'b0100 with MEM_BUSY=1 for 10 cycles, then MEM_BUSY=0 → EN stays 0 for those cycles; EN=0100 one cycle after MEM_BUSY falls.
- TIMEOUT=8, REQ[1] held for 20 cycles (macro defined) → EN[1] high for exactly 8 cycles; TIMEOUT_ERR pulses once; ERR_ID=1; unit 1 not regranted until REQ[1] drops and rises again.
- Assert RESET=0 mid-grant (unit 2) → EN=0 and BUS_BUSY=0 without a clock edge; after release, REQ=0101 grants unit 0 first.
- Macro undefined, REQ[3] held 200 cycles → EN[3] held all 200 cycles; TIMEOUT_ERR stays 0.
